// File: rtl/main_fsm_if.sv
// Bus bundle between the FFT/readout side and the pitch-correction core.
// The core uses the slave modport; the FFT/output side uses master.
interface main_fsm_if #(
  parameter int DW = 18
);
  logic [11:0]          scale;
  logic                 fft_done;
  logic [8:0]           fft_address;
  logic                 fft_read_valid;
  logic signed [DW-1:0] data_in_real;
  logic signed [DW-1:0] data_in_imag;
  logic [8:0]           result_address;
  logic [2*DW-1:0]      result_data;
  logic                 done;
  logic                 note_done;
  logic [3:0]           note_name;
  logic [2:0]           note_octave;

  modport master (
    output scale, fft_done, fft_address, fft_read_valid,
    output data_in_real, data_in_imag, result_address,
    input  result_data, done, note_done, note_name, note_octave
  );

  modport slave (
    input  scale, fft_done, fft_address, fft_read_valid,
    input  data_in_real, data_in_imag, result_address,
    output result_data, done, note_done, note_name, note_octave
  );
endinterface

// File: rtl/main_fsm.sv
// Pitch-correction core: peak detect, note snap, spectrum shift.
// Result buffer is read by address with one cycle of latency.
module main_fsm #(
  parameter int N_BINS = 512,
  parameter int DW     = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  main_fsm_if.slave  bus
);
  localparam int AW   = $clog2(N_BINS);
  localparam int HALF = N_BINS / 2;

  typedef enum logic [1:0] {
    CAPTURE, DETECT, SNAP, SHIFT
  } state_t;

  state_t            r_state;
  logic [2*DW-1:0]   r_in_buf  [N_BINS];
  logic [2*DW-1:0]   r_res_buf [N_BINS];
  logic              r_fd_q;
  logic [DW:0]       r_peak_mag;
  logic [7:0]        r_peak_bin;
  logic [3:0]        r_n;
  logic [2:0]        r_oct;
  logic [2:0]        r_s;
  logic              r_nosig;
  logic signed [9:0] r_offset;
  logic [AW-1:0]     r_j;
  logic              r_done;
  logic              r_note_done;
  logic [3:0]        r_note_name;
  logic [2:0]        r_note_octave;
  logic [2*DW-1:0]   r_result;

  function automatic logic [7:0] f_th(input logic [3:0] i);
    case (i)
      4'd0:    f_th = 8'd132;
      4'd1:    f_th = 8'd140;
      4'd2:    f_th = 8'd148;
      4'd3:    f_th = 8'd157;
      4'd4:    f_th = 8'd166;
      4'd5:    f_th = 8'd176;
      4'd6:    f_th = 8'd186;
      4'd7:    f_th = 8'd197;
      4'd8:    f_th = 8'd209;
      4'd9:    f_th = 8'd222;
      4'd10:   f_th = 8'd235;
      default: f_th = 8'd249;
    endcase
  endfunction

  function automatic logic [7:0] f_ctr(input logic [3:0] i);
    case (i)
      4'd0:    f_ctr = 8'd128;
      4'd1:    f_ctr = 8'd136;
      4'd2:    f_ctr = 8'd144;
      4'd3:    f_ctr = 8'd152;
      4'd4:    f_ctr = 8'd161;
      4'd5:    f_ctr = 8'd171;
      4'd6:    f_ctr = 8'd181;
      4'd7:    f_ctr = 8'd192;
      4'd8:    f_ctr = 8'd203;
      4'd9:    f_ctr = 8'd215;
      4'd10:   f_ctr = 8'd228;
      default: f_ctr = 8'd242;
    endcase
  endfunction

  logic [DW-1:0] w_abs_re;
  logic [DW-1:0] w_abs_im;
  logic [DW:0]   w_mag;
  logic [DW:0]   w_base;
  logic          w_in_range;
  logic          w_win;
  logic          w_edge;
  logic          w_cap_we;

  assign w_abs_re = bus.data_in_real[DW-1] ?
                    DW'(-bus.data_in_real) : DW'(bus.data_in_real);
  assign w_abs_im = bus.data_in_imag[DW-1] ?
                    DW'(-bus.data_in_imag) : DW'(bus.data_in_imag);
  assign w_mag    = {1'b0, w_abs_re} + {1'b0, w_abs_im};
  assign w_in_range = (bus.fft_address != '0) &&
                      (bus.fft_address < AW'(HALF));
  // A finished frame's peak is stale once the next frame starts.
  assign w_base   = r_done ? '0 : r_peak_mag;
  assign w_win    = w_in_range && (w_mag > w_base);
  assign w_edge   = bus.fft_done && !r_fd_q;
  assign w_cap_we = (r_state == CAPTURE) && bus.fft_read_valid;

  logic [2:0] w_s;
  logic [7:0] w_k;
  logic [3:0] w_cnt;

  always_comb begin
    w_s = '0;
    for (int i = 0; i < 8; i++)
      if (r_peak_bin[i]) w_s = 3'(7 - i);
    w_k   = r_peak_bin << w_s;
    w_cnt = '0;
    for (int i = 0; i < 12; i++)
      if (w_k >= f_th(4'(i))) w_cnt = w_cnt + 4'd1;
  end

  logic [3:0] w_t;
  logic [3:0] w_li;
  logic [4:0] w_sum;
  logic [3:0] w_hi_i;
  logic       w_lo_wrap;
  logic       w_hi_wrap;
  logic       w_found;

  // Nearest allowed note; downward neighbour wins a tie.
  always_comb begin
    w_t       = r_n;
    w_li      = '0;
    w_sum     = '0;
    w_hi_i    = '0;
    w_lo_wrap = 1'b0;
    w_hi_wrap = 1'b0;
    w_found   = 1'b0;
    if (bus.scale != '0 && !r_nosig) begin
      for (int d = 0; d < 7; d++) begin
        if (!w_found) begin
          w_li   = (r_n >= 4'(d)) ? r_n - 4'(d) : r_n + 4'(12 - d);
          w_sum  = {1'b0, r_n} + 5'(d);
          w_hi_i = (w_sum > 5'd11) ? 4'(w_sum - 5'd12) : w_sum[3:0];
          if (bus.scale[w_li]) begin
            w_t       = w_li;
            w_lo_wrap = r_n < 4'(d);
            w_found   = 1'b1;
          end else if (bus.scale[w_hi_i]) begin
            w_t       = w_hi_i;
            w_hi_wrap = w_sum > 5'd11;
            w_found   = 1'b1;
          end
        end
      end
    end
  end

  logic [7:0]        w_c;
  logic [8:0]        w_cadj;
  logic [8:0]        w_target;
  logic signed [9:0] w_off;

  assign w_c      = f_ctr(w_t);
  assign w_cadj   = w_lo_wrap ? {2'b00, w_c[7:1]} :
                    w_hi_wrap ? {w_c, 1'b0} : {1'b0, w_c};
  assign w_target = w_cadj >> r_s;
  assign w_off    = $signed({1'b0, w_target}) -
                    $signed({2'b00, r_peak_bin});

  logic signed [11:0] w_jx;
  logic signed [11:0] w_offx;
  logic signed [11:0] w_src;
  logic               w_low;
  logic               w_src_ok;
  logic [2*DW-1:0]    w_shift_data;

  assign w_jx     = $signed({3'b000, r_j});
  assign w_offx   = $signed({{2{r_offset[9]}}, r_offset});
  assign w_low    = !r_j[AW-1];
  assign w_src    = w_low ? w_jx - w_offx : w_jx + w_offx;
  assign w_src_ok = w_low ?
    (w_src >= 12'sd0 && w_src < 12'sd256) :
    (w_src >= 12'sd256 && w_src < 12'sd512);
  assign w_shift_data = w_src_ok ? r_in_buf[w_src[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (w_cap_we)
      r_in_buf[bus.fft_address] <=
        {bus.data_in_real, bus.data_in_imag};
    if (r_state == SHIFT)
      r_res_buf[r_j] <= w_shift_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= CAPTURE;
      r_fd_q        <= 1'b0;
      r_peak_mag    <= '0;
      r_peak_bin    <= '0;
      r_n           <= '0;
      r_oct         <= '0;
      r_s           <= '0;
      r_nosig       <= 1'b0;
      r_offset      <= '0;
      r_j           <= '0;
      r_done        <= 1'b0;
      r_note_done   <= 1'b0;
      r_note_name   <= '0;
      r_note_octave <= '0;
      r_result      <= '0;
    end else begin
      r_fd_q      <= bus.fft_done;
      r_note_done <= 1'b0;
      r_result    <= r_res_buf[bus.result_address];
      case (r_state)
        CAPTURE: begin
          if (bus.fft_read_valid) begin
            if (r_done) begin
              r_done     <= 1'b0;
              r_peak_mag <= '0;
              r_peak_bin <= '0;
            end
            if (w_win) begin
              r_peak_mag <= w_mag;
              r_peak_bin <= bus.fft_address[7:0];
            end
          end
          if (w_edge) r_state <= DETECT;
        end
        DETECT: begin
          r_s     <= w_s;
          r_nosig <= (r_peak_mag == '0);
          if (r_peak_mag == '0) begin
            r_n   <= 4'd15;
            r_oct <= 3'd0;
          end else if (w_cnt == 4'd12) begin
            r_n   <= 4'd0;
            r_oct <= (w_s == 3'd0) ? 3'd7 : 3'd7 - w_s + 3'd1;
          end else begin
            r_n   <= w_cnt;
            r_oct <= 3'd7 - w_s;
          end
          r_state <= SNAP;
        end
        SNAP: begin
          r_note_done   <= 1'b1;
          r_note_name   <= r_n;
          r_note_octave <= r_oct;
          r_offset      <= r_nosig ? '0 : w_off;
          r_j           <= '0;
          r_state       <= SHIFT;
        end
        SHIFT: begin
          r_j <= r_j + 1'b1;
          if (r_j == AW'(N_BINS - 1)) begin
            r_done  <= 1'b1;
            r_state <= CAPTURE;
          end
        end
        default: r_state <= CAPTURE;
      endcase
    end
  end

  assign bus.result_data = r_result;
  assign bus.done        = r_done;
  assign bus.note_done   = r_note_done;
  assign bus.note_name   = r_note_name;
  assign bus.note_octave = r_note_octave;
endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: note detection, snap/shift results,
// reset behaviour and result read latency.
module tb_main_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_fsm_if bus();

  main_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tot = 0;
  int n_bad = 0;
  logic signed [17:0] fr_re [512];
  logic signed [17:0] fr_im [512];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input int re, input int im);
    return {18'(re), 18'(im)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 512; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic send_frame();
    for (int a = 0; a < 512; a++) begin
      bus.fft_read_valid = 1'b1;
      bus.fft_address    = 9'(a);
      bus.data_in_real   = fr_re[a];
      bus.data_in_imag   = fr_im[a];
      bus.fft_done       = (a == 511);
      tick();
    end
    bus.fft_read_valid = 1'b0;
    bus.fft_done       = 1'b0;
  endtask

  task automatic run(input string tag, input logic [11:0] sc,
                     input logic [3:0] en, input logic [2:0] eo,
                     input bit full);
    bus.scale = sc;
    send_frame();
    chk({tag, ".done0"}, bus.done, 0);
    chk({tag, ".nd0"}, bus.note_done, 0);
    tick();
    chk({tag, ".nd1"}, bus.note_done, 0);
    tick();
    chk({tag, ".nd2"}, bus.note_done, 1);
    chk({tag, ".name"}, bus.note_name, en);
    chk({tag, ".oct"}, bus.note_octave, eo);
    tick();
    chk({tag, ".nd3"}, bus.note_done, 0);
    if (full) begin
      for (int i = 0; i < 600 && bus.done !== 1'b1; i++) tick();
      chk({tag, ".done"}, bus.done, 1);
    end
  endtask

  task automatic rdchk(input string tag, input int a,
                       input logic [35:0] exp);
    bus.result_address = 9'(a);
    tick();
    chk($sformatf("%s.r%0d", tag, a), bus.result_data, exp);
  endtask

  task automatic tie_frame();
    clr();
    fr_re[0]   = 18'sd5000;
    fr_re[100] = 18'sd300;
    fr_re[200] = -18'sd150;
    fr_im[200] = 18'sd150;
    fr_re[256] = 18'sd17;
    fr_re[257] = 18'sd13;
    fr_re[300] = 18'sd9000;
    fr_re[511] = 18'sd7;
  endtask

  initial begin
    int np;
    bus.scale          = 12'hFFF;
    bus.fft_done       = 1'b0;
    bus.fft_address    = '0;
    bus.fft_read_valid = 1'b0;
    bus.data_in_real   = '0;
    bus.data_in_imag   = '0;
    bus.result_address = '0;
    repeat (3) tick();
    chk("rst.done", bus.done, 0);
    chk("rst.nd", bus.note_done, 0);
    chk("rst.name", bus.note_name, 0);
    chk("rst.oct", bus.note_octave, 0);
    chk("rst.data", bus.result_data, 0);
    rst_n = 1'b1;
    tick();

    clr();
    fr_re[128] = 18'sd1000;
    run("A", 12'hFFF, 4'd0, 3'd7, 1'b1);
    for (int a = 0; a < 256; a++)
      rdchk("A", a, (a == 128) ? mk(1000, 0) : 36'h0);

    clr();
    fr_re[64] = 18'sd1000;
    run("B", 12'hFFF, 4'd0, 3'd6, 1'b1);
    rdchk("B", 64, mk(1000, 0));
    rdchk("B", 128, 36'h0);

    clr();
    fr_re[140] = 18'sd500;
    run("C", 12'h001, 4'd2, 3'd7, 1'b1);
    rdchk("C", 128, mk(500, 0));
    rdchk("C", 116, 36'h0);
    rdchk("C", 140, 36'h0);

    tie_frame();
    run("T", 12'hFFF, 4'd8, 3'd6, 1'b1);
    rdchk("T", 0, 36'h0);
    rdchk("T", 1, mk(5000, 0));
    rdchk("T", 101, mk(300, 0));
    rdchk("T", 201, mk(-150, 150));
    rdchk("T", 255, 36'h0);
    rdchk("T", 256, mk(13, 0));
    rdchk("T", 299, mk(9000, 0));
    rdchk("T", 510, mk(7, 0));
    rdchk("T", 511, 36'h0);

    clr();
    run("Z", 12'hFFF, 4'd15, 3'd0, 1'b1);
    for (int a = 0; a < 512; a++) rdchk("Z", a, 36'h0);

    clr();
    fr_re[140] = 18'sd500;
    run("R", 12'h001, 4'd2, 3'd7, 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("R.done", bus.done, 0);
    chk("R.nd", bus.note_done, 0);
    chk("R.name", bus.note_name, 0);
    chk("R.oct", bus.note_octave, 0);
    chk("R.data", bus.result_data, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.note_done === 1'b1) np++;
    end
    chk("R.pulses", np, 0);

    tie_frame();
    run("R2", 12'hFFF, 4'd8, 3'd6, 1'b1);
    rdchk("R2", 101, mk(300, 0));
    bus.result_address = 9'd1;
    #2;
    chk("lat.hold", bus.result_data, mk(300, 0));
    tick();
    chk("lat.new", bus.result_data, mk(5000, 0));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
